// File: rtl/noc_input_buffer.sv
// Per-input-port flit FIFO with dimension-order route computation for the head flit.
// Define NOC_ROUTE_YX_EN to resolve Y before X (YX routing); XY routing otherwise.
module noc_input_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned FLIT_W  = 32,
  parameter int unsigned COORD_W = 2,
  parameter int unsigned MY_X    = 0,
  parameter int unsigned MY_Y    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [FLIT_W-1:0]          in_flit,
  output logic                       in_ready,
  output logic                       buf_request,
  output logic [4:0]                 buf_route,
  output logic [FLIT_W-1:0]          buf_flit,
  input  logic                       buf_grant,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
  localparam logic [COORD_W-1:0] MY_X_C   = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_Y_C   = COORD_W'(MY_Y);

  typedef enum logic [2:0] {
    PortNorth = 3'b000,
    PortEast  = 3'b001,
    PortSouth = 3'b010,
    PortWest  = 3'b011,
    PortLocal = 3'b100
  } port_e;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop, empty;
  logic [FLIT_W-1:0] head;
  logic [COORD_W-1:0] dest_x, dest_y;
  port_e             port;

  assign empty       = (count_q == '0);
  assign in_ready    = (count_q != FULL_CNT);
  assign buf_request = !empty;
  assign push        = in_valid && in_ready;
  // Grant while empty is ignored because buf_request is low.
  assign pop         = buf_grant && buf_request;
  assign count       = count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_flit;
  end

  assign head     = mem_q[rd_ptr_q];
  assign dest_x   = head[2*COORD_W-1:COORD_W];
  assign dest_y   = head[COORD_W-1:0];
  assign buf_flit = empty ? '0 : head;

  always_comb begin
    port = PortLocal;
`ifdef NOC_ROUTE_YX_EN
    if (dest_y > MY_Y_C)      port = PortNorth;
    else if (dest_y < MY_Y_C) port = PortSouth;
    else if (dest_x > MY_X_C) port = PortEast;
    else if (dest_x < MY_X_C) port = PortWest;
    else                      port = PortLocal;
`else
    if (dest_x > MY_X_C)      port = PortEast;
    else if (dest_x < MY_X_C) port = PortWest;
    else if (dest_y > MY_Y_C) port = PortNorth;
    else if (dest_y < MY_Y_C) port = PortSouth;
    else                      port = PortLocal;
`endif
  end

  // 3'b111 is not a port code, so an empty buffer never matches in the allocator.
  assign buf_route = empty ? 5'b11100 : {port, 2'b00};

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed self-checking bench for noc_input_buffer (DEPTH=4, router at (1,1)).
module tb_noc_input_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_flit;
  logic        in_ready;
  logic        buf_request;
  logic [4:0]  buf_route;
  logic [31:0] buf_flit;
  logic        buf_grant;
  logic [2:0]  count;

  int passed = 0;
  int total  = 0;

  noc_input_buffer #(
    .DEPTH(4), .FLIT_W(32), .COORD_W(2), .MY_X(1), .MY_Y(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
    .buf_request(buf_request), .buf_route(buf_route), .buf_flit(buf_flit),
    .buf_grant(buf_grant), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [27:0] pl, input logic [1:0] x,
                                     input logic [1:0] y);
    return {pl, x, y};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_flit = '0; buf_grant = 1'b0;
    step(); step();
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passed++;
    total++; if (buf_request !== 1'b0) $display("FAIL reset_request: got %b want 0", buf_request);
    else passed++;
    total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count);
    else passed++;
    total++; if (buf_route !== 5'b11100) $display("FAIL reset_route: got %b want 11100", buf_route);
    else passed++;
    total++; if (buf_flit !== 32'h0) $display("FAIL reset_flit: got %h want 0", buf_flit);
    else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] f;
    f = mk(28'h11, 2'd3, 2'd1);
    in_valid = 1'b1; in_flit = f;
    step();
    in_valid = 1'b0;
    total++; if (buf_request !== 1'b1) $display("FAIL basic_request: got %b want 1", buf_request);
    else passed++;
    total++; if (buf_route !== 5'b00100) $display("FAIL basic_route: got %b want 00100", buf_route);
    else passed++;
    total++; if (buf_flit !== f) $display("FAIL basic_flit: got %h want %h", buf_flit, f);
    else passed++;
    buf_grant = 1'b1;
    step();
    buf_grant = 1'b0;
    total++; if (count !== 3'd0) $display("FAIL basic_count_after_pop: got %0d want 0", count);
    else passed++;
    total++; if (buf_request !== 1'b0) $display("FAIL basic_request_after_pop: got %b want 0", buf_request);
    else passed++;
    // Grant while empty must not disturb state.
    buf_grant = 1'b1;
    step();
    buf_grant = 1'b0;
    total++; if (count !== 3'd0) $display("FAIL empty_grant_count: got %0d want 0", count);
    else passed++;
  endtask

  task automatic test_full();
    logic [31:0] f [5];
    for (int i = 0; i < 5; i++) f[i] = mk(28'hA0 + 28'(i), 2'd1, 2'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_flit = f[i];
      step();
    end
    total++; if (count !== 3'd4) $display("FAIL full_count: got %0d want 4", count);
    else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", in_ready);
    else passed++;
    in_flit = f[4];
    step();
    total++; if (count !== 3'd4) $display("FAIL full_hold_count: got %0d want 4", count);
    else passed++;
    total++; if (buf_flit !== f[0]) $display("FAIL full_head_a: got %h want %h", buf_flit, f[0]);
    else passed++;
    buf_grant = 1'b1;
    step();
    buf_grant = 1'b0;
    total++; if (in_ready !== 1'b1) $display("FAIL full_ready_after_pop: got %b want 1", in_ready);
    else passed++;
    total++; if (count !== 3'd3) $display("FAIL full_no_passthrough: got %0d want 3", count);
    else passed++;
    step();
    in_valid = 1'b0;
    total++; if (count !== 3'd4) $display("FAIL full_e_accepted: got %0d want 4", count);
    else passed++;
    for (int i = 1; i < 5; i++) begin
      total++; if (buf_flit !== f[i]) $display("FAIL drain_order_%0d: got %h want %h", i, buf_flit, f[i]);
      else passed++;
      buf_grant = 1'b1;
      step();
    end
    buf_grant = 1'b0;
    total++; if (count !== 3'd0) $display("FAIL drain_count: got %0d want 0", count);
    else passed++;
  endtask

  task automatic test_simul();
    logic [31:0] p [8];
    for (int i = 0; i < 8; i++) p[i] = mk(28'h500 + 28'(i), 2'd1, 2'd1);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_flit = p[i];
      step();
    end
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_flit = p[k+2]; buf_grant = 1'b1;
      total++; if (buf_flit !== p[k]) $display("FAIL simul_head_%0d: got %h want %h", k, buf_flit, p[k]);
      else passed++;
      step();
      total++; if (count !== 3'd2) $display("FAIL simul_count_%0d: got %0d want 2", k, count);
      else passed++;
    end
    in_valid = 1'b0;
    for (int k = 6; k < 8; k++) begin
      total++; if (buf_flit !== p[k]) $display("FAIL simul_tail_%0d: got %h want %h", k, buf_flit, p[k]);
      else passed++;
      step();
    end
    buf_grant = 1'b0;
    total++; if (count !== 3'd0) $display("FAIL simul_drain: got %0d want 0", count);
    else passed++;
  endtask

  task automatic test_route();
    logic [1:0] xs [3];
    logic [1:0] ys [3];
    logic [4:0] exp_r [3];
    xs[0] = 2'd1; ys[0] = 2'd1; exp_r[0] = 5'b10000;
    xs[1] = 2'd0; ys[1] = 2'd3;
`ifdef NOC_ROUTE_YX_EN
    exp_r[1] = 5'b00000;
`else
    exp_r[1] = 5'b01100;
`endif
    xs[2] = 2'd1; ys[2] = 2'd0; exp_r[2] = 5'b01000;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_flit = mk(28'h700 + 28'(i), xs[i], ys[i]);
      step();
      in_valid = 1'b0;
      total++; if (buf_route !== exp_r[i])
        $display("FAIL route_%0d_dest_%0d_%0d: got %b want %b", i, xs[i], ys[i], buf_route, exp_r[i]);
      else passed++;
      buf_grant = 1'b1;
      step();
      buf_grant = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] f;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_flit = mk(28'h900 + 28'(i), 2'd2, 2'd2);
      step();
    end
    in_valid = 1'b0;
    total++; if (count !== 3'd3) $display("FAIL midrst_pre_count: got %0d want 3", count);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (count !== 3'd0) $display("FAIL midrst_count: got %0d want 0", count);
    else passed++;
    total++; if (buf_request !== 1'b0) $display("FAIL midrst_request: got %b want 0", buf_request);
    else passed++;
    rst = 1'b0;
    f = mk(28'hBEE, 2'd1, 2'd2);
    in_valid = 1'b1; in_flit = f;
    step();
    in_valid = 1'b0;
    total++; if (count !== 3'd1) $display("FAIL midrst_push_count: got %0d want 1", count);
    else passed++;
    total++; if (buf_flit !== f) $display("FAIL midrst_push_flit: got %h want %h", buf_flit, f);
    else passed++;
    total++; if (buf_route !== 5'b00000) $display("FAIL midrst_push_route: got %b want 00000", buf_route);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_simul();
    test_route();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
